// File: rtl/serial_gt_ctrl.sv
// Serial MSB-first magnitude comparator: one 2-bit slice per clock, with a start/ready/done handshake.
// Result outputs are registered and hold until the next accepted start.
module serial_gt_ctrl #(
   parameter int W          = 16,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int CW        = $clog2(W/2) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          ready,
   output logic          done,
   output logic          gt,
   output logic          eq,
   output logic          lt,
   output logic [CW-1:0] cycles
);

   if (W < 2 || (W % 2) != 0) begin : g_bad_width
      $error("serial_gt_ctrl: W must be even and >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

   localparam logic [CW-1:0] IDX_TOP = CW'(W/2 - 1);

   state_t          state, state_n;
   logic [W-1:0]    sh_a, sh_a_n, sh_b, sh_b_n;
   logic [CW-1:0]   idx, idx_n, cycles_n;
   logic            rec_gt, rec_gt_n, rec_lt, rec_lt_n;
   logic            ready_n, done_n, gt_n, eq_n, lt_n;
   logic            s_gt, s_lt;
   logic [1:0]      sa, sb;

   assign sa = sh_a[W-1 -: 2];
   assign sb = sh_b[W-1 -: 2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         sh_a   <= '0;
         sh_b   <= '0;
         idx    <= '0;
         rec_gt <= 1'b0;
         rec_lt <= 1'b0;
         ready  <= 1'b0;
         done   <= 1'b0;
         gt     <= 1'b0;
         eq     <= 1'b0;
         lt     <= 1'b0;
         cycles <= '0;
      end else begin
         state  <= state_n;
         sh_a   <= sh_a_n;
         sh_b   <= sh_b_n;
         idx    <= idx_n;
         rec_gt <= rec_gt_n;
         rec_lt <= rec_lt_n;
         ready  <= ready_n;
         done   <= done_n;
         gt     <= gt_n;
         eq     <= eq_n;
         lt     <= lt_n;
         cycles <= cycles_n;
      end
   end

   always_comb begin
      state_n  = state;
      sh_a_n   = sh_a;
      sh_b_n   = sh_b;
      idx_n    = idx;
      rec_gt_n = rec_gt;
      rec_lt_n = rec_lt;
      ready_n  = 1'b0;
      done_n   = 1'b0;
      gt_n     = gt;
      eq_n     = eq;
      lt_n     = lt;
      cycles_n = cycles;
      s_gt     = 1'b0;
      s_lt     = 1'b0;
      case (state)
         S_IDLE: begin
            // ready is still low on the first cycle out of reset, so start is ignored there
            if (ready && start) begin
               sh_a_n   = a;
               sh_b_n   = b;
               idx_n    = IDX_TOP;
               rec_gt_n = 1'b0;
               rec_lt_n = 1'b0;
               gt_n     = 1'b0;
               eq_n     = 1'b0;
               lt_n     = 1'b0;
               cycles_n = '0;
               state_n  = S_COMPARE;
            end else begin
               ready_n = 1'b1;
            end
         end
         S_COMPARE: begin
            s_gt     = !(rec_gt || rec_lt) && (sa > sb);
            s_lt     = !(rec_gt || rec_lt) && (sa < sb);
            rec_gt_n = rec_gt || s_gt;
            rec_lt_n = rec_lt || s_lt;
            cycles_n = cycles + CW'(1);
            if ((EARLY_EXIT && (s_gt || s_lt)) || idx == '0) begin
               state_n = S_DONE;
               done_n  = 1'b1;
               gt_n    = rec_gt_n;
               lt_n    = rec_lt_n;
               eq_n    = !(rec_gt_n || rec_lt_n);
            end else begin
               sh_a_n = sh_a << 2;
               sh_b_n = sh_b << 2;
               idx_n  = idx - CW'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            ready_n = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
